// File: rtl/hazard_scoreboard_if.sv
// Issue-side bus between the ID stage and the hazard scoreboard.
// The ID stage (master) presents the decoded instruction; the scoreboard
// (slave) answers with a combinational stall request.
interface hazard_scoreboard_if #(
    parameter int REG_W = 4
) ();
    logic             forward_en_i;
    logic             issue_valid_i;
    logic [REG_W-1:0] src1_i;
    logic [REG_W-1:0] src2_i;
    logic             two_src_i;
    logic             issue_wb_en_i;
    logic [REG_W-1:0] issue_dest_i;
    logic             issue_mem_read_i;
    logic             flush_i;
    logic             hazard_o;

    modport master (
        output forward_en_i,
        output issue_valid_i,
        output src1_i,
        output src2_i,
        output two_src_i,
        output issue_wb_en_i,
        output issue_dest_i,
        output issue_mem_read_i,
        output flush_i,
        input  hazard_o
    );

    modport slave (
        input  forward_en_i,
        input  issue_valid_i,
        input  src1_i,
        input  src2_i,
        input  two_src_i,
        input  issue_wb_en_i,
        input  issue_dest_i,
        input  issue_mem_read_i,
        input  flush_i,
        output hazard_o
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit for the ID stage.
// Every issued register write loads a per-register countdown of the cycles it
// remains in flight; source operands are checked against those countdowns to
// decide whether PC/IF-ID must freeze and a bubble go into ID-EX. With
// forwarding enabled only a load still sitting in EX forces a stall.
module hazard_scoreboard #(
    parameter int REG_COUNT = 16,
    parameter int REG_W     = 4,
    parameter int LAT       = 2,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_scoreboard_if.slave   bus,
    output logic [REG_COUNT-1:0] busy_o,
    output logic [CNT_W-1:0]     stall_count_o
);

    localparam logic [2:0]       LAT3    = 3'(LAT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [REG_COUNT-1:0][2:0] cnt_q;
    logic [REG_COUNT-1:0][2:0] cnt_d;
    logic [REG_COUNT-1:0]      ld_q;
    logic [REG_COUNT-1:0]      ld_d;
    logic [CNT_W-1:0]          stallCount_q;
    logic [CNT_W-1:0]          stallCount_d;

    logic [2:0] src1Cnt;
    logic [2:0] src2Cnt;
    logic       src1Ld;
    logic       src2Ld;
    logic       stall1;
    logic       stall2;
    logic       hazard;
    logic       issue;

    // Look up both source operands against pre-issue state and form the stall request.
    always_comb begin
        src1Cnt = 3'd0;
        src2Cnt = 3'd0;
        src1Ld  = 1'b0;
        src2Ld  = 1'b0;
        if (int'(bus.src1_i) < REG_COUNT) begin
            src1Cnt = cnt_q[bus.src1_i];
            src1Ld  = ld_q[bus.src1_i];
        end
        if (int'(bus.src2_i) < REG_COUNT) begin
            src2Cnt = cnt_q[bus.src2_i];
            src2Ld  = ld_q[bus.src2_i];
        end
        if (bus.forward_en_i) begin
            stall1 = src1Ld && (src1Cnt == LAT3);
            stall2 = bus.two_src_i && src2Ld && (src2Cnt == LAT3);
        end else begin
            stall1 = (src1Cnt != 3'd0);
            stall2 = bus.two_src_i && (src2Cnt != 3'd0);
        end
        hazard = bus.issue_valid_i && !bus.flush_i && (stall1 || stall2);
        issue  = bus.issue_valid_i && !hazard && !bus.flush_i && bus.issue_wb_en_i;
    end

    assign bus.hazard_o = hazard;

    // Next countdown per register: a fresh issue reloads it, otherwise it drains to zero.
    always_comb begin
        cnt_d = cnt_q;
        ld_d  = ld_q;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (issue && (int'(bus.issue_dest_i) == i)) begin
                cnt_d[i] = LAT3;
                ld_d[i]  = bus.issue_mem_read_i;
            end else if (cnt_q[i] != 3'd0) begin
                cnt_d[i] = cnt_q[i] - 3'd1;
                if (cnt_q[i] == 3'd1) begin
                    ld_d[i] = 1'b0;
                end
            end
        end
    end

    // Saturating count of cycles spent stalled.
    always_comb begin
        stallCount_d = stallCount_q;
        if (hazard && (stallCount_q != CNT_MAX)) begin
            stallCount_d = stallCount_q + CNT_W'(1);
        end
    end

    // State registers; reset wins over any issue presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            ld_q         <= '0;
            stallCount_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            ld_q         <= ld_d;
            stallCount_q <= stallCount_d;
        end
    end

    // Busy view is derived purely from the registered countdowns.
    always_comb begin
        busy_o = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            busy_o[i] = (cnt_q[i] != 3'd0);
        end
    end

    assign stall_count_o = stallCount_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios followed by random traffic,
// all compared against a timestamp-based model of in-flight register writes.
module tb_hazard_scoreboard;

    localparam int REG_COUNT = 16;
    localparam int REG_W     = 4;
    localparam int LAT       = 2;
    localparam int CNT_W     = 3;
    localparam int CNT_MAX   = 7;
    localparam int NEVER     = -1000;

    logic                 clk;
    logic                 rst;
    logic [REG_COUNT-1:0] busy;
    logic [CNT_W-1:0]     stallCount;

    hazard_scoreboard_if #(.REG_W(REG_W)) bus ();

    hazard_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .REG_W     (REG_W),
        .LAT       (LAT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .busy_o        (busy),
        .stall_count_o (stallCount)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int compared;
    int mismatched;

    int now;
    int issueAt   [REG_COUNT];
    bit isLoad    [REG_COUNT];
    int modelCount;

    bit                   expHazard;
    bit                   expIssue;
    logic [REG_COUNT-1:0] expBusy;
    logic [CNT_W-1:0]     expCount;

    function automatic int remaining(input int r);
        int age;
        age = now - issueAt[r];
        if (age >= 1 && age <= LAT) return LAT + 1 - age;
        return 0;
    endfunction

    function automatic bit stallOn(input int r, input bit fwd);
        if (fwd) return isLoad[r] && ((now - issueAt[r]) == 1);
        return remaining(r) != 0;
    endfunction

    // Drive one cycle of inputs mid-cycle and predict the outputs from the model.
    task automatic applyStimulus(input bit rstV, input bit fwd, input bit valid,
                                 input int s1, input int s2, input bit two,
                                 input bit wb, input int dest, input bit memRd,
                                 input bit fl);
        @(negedge clk);
        rst                  = rstV;
        bus.forward_en_i     = fwd;
        bus.issue_valid_i    = valid;
        bus.src1_i           = REG_W'(s1);
        bus.src2_i           = REG_W'(s2);
        bus.two_src_i        = two;
        bus.issue_wb_en_i    = wb;
        bus.issue_dest_i     = REG_W'(dest);
        bus.issue_mem_read_i = memRd;
        bus.flush_i          = fl;
        #1;
        expHazard = valid && !fl && (stallOn(s1, fwd) || (two && stallOn(s2, fwd)));
        expIssue  = valid && !expHazard && !fl && wb;
        for (int i = 0; i < REG_COUNT; i++) expBusy[i] = (remaining(i) != 0);
        expCount = CNT_W'(modelCount);
    endtask

    // Apply the effect of the coming clock edge to the model.
    task automatic advanceModel();
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                issueAt[i] = NEVER;
                isLoad[i]  = 1'b0;
            end
            modelCount = 0;
        end else begin
            if (expHazard && modelCount < CNT_MAX) modelCount++;
            if (expIssue) begin
                issueAt[int'(bus.issue_dest_i)] = now;
                isLoad[int'(bus.issue_dest_i)]  = bus.issue_mem_read_i;
            end
        end
        now++;
    endtask

    task automatic checkOutput(input string tag);
        compared++;
        assert (bus.hazard_o === expHazard) else begin
            mismatched++;
            $error("[TB] FAIL %s hazard: observed %0b expected %0b", tag, bus.hazard_o, expHazard);
        end
        compared++;
        assert (busy === expBusy) else begin
            mismatched++;
            $error("[TB] FAIL %s busy: observed %h expected %h", tag, busy, expBusy);
        end
        compared++;
        assert (stallCount === expCount) else begin
            mismatched++;
            $error("[TB] FAIL %s stall_count: observed %0d expected %0d", tag, stallCount, expCount);
        end
        advanceModel();
    endtask

    // Directed scenarios followed by random traffic.
    initial begin
        compared   = 0;
        mismatched = 0;
        now        = 0;
        modelCount = 0;
        for (int i = 0; i < REG_COUNT; i++) begin
            issueAt[i] = NEVER;
            isLoad[i]  = 1'b0;
        end

        // Reset held two cycles while a write is offered; the first cycle has undefined state.
        applyStimulus(1, 0, 1, 3, 0, 0, 1, 3, 0, 0);
        advanceModel();
        applyStimulus(1, 0, 1, 3, 0, 0, 1, 3, 0, 0);
        checkOutput("reset");
        applyStimulus(0, 0, 1, 3, 3, 1, 0, 0, 0, 0);
        checkOutput("post_reset");
        compared++;
        assert (busy === '0 && stallCount === '0 && bus.hazard_o === 1'b0) else begin
            mismatched++;
            $error("[TB] FAIL reset_clean: observed busy=%h cnt=%0d hz=%0b expected all zero",
                   busy, stallCount, bus.hazard_o);
        end

        // No forwarding: ADD R3 then dependent SUB stalls two cycles.
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 3, 0, 0);
        checkOutput("nofwd_issue");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, 3, 0, 0, 1, 4, 0, 0);
            checkOutput($sformatf("nofwd_dep%0d", k));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("nofwd_count");
        compared++;
        assert (stallCount === CNT_W'(2)) else begin
            mismatched++;
            $error("[TB] FAIL nofwd_total: observed %0d expected 2", stallCount);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("drain1");
        end

        // Forwarding: load-use stalls once; single-source instruction ignores src2.
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 5, 1, 0);
        checkOutput("fwd_ldr");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 1, 1, 1, 5, 1, 1, 6, 0, 0);
            checkOutput($sformatf("fwd_use%0d", k));
        end
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 5, 1, 0);
        checkOutput("fwd_ldr2");
        applyStimulus(0, 1, 1, 1, 5, 0, 1, 6, 0, 0);
        checkOutput("fwd_onesrc");
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 8, 0, 0);
        checkOutput("fwd_alu");
        applyStimulus(0, 1, 1, 8, 0, 0, 1, 9, 0, 0);
        checkOutput("fwd_alu_use");

        // Overwrite: R7 issued on back-to-back cycles.
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 7, 0, 0);
        checkOutput("ovw_a");
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 7, 0, 0);
        checkOutput("ovw_b");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("ovw_t%0d", k + 2));
        end

        // Flush blocks both the stall and the write.
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 2, 0, 1);
        checkOutput("flush");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush_after");

        // Ten more stall cycles push the 3-bit counter into saturation.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 1, 0, 0, 0, 1, 9, 0, 0);
            checkOutput("sat_writer");
            for (int j = 0; j < 3; j++) begin
                applyStimulus(0, 0, 1, 9, 0, 0, 1, 10, 0, 0);
                checkOutput("sat_dep");
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sat_hold");
        compared++;
        assert (stallCount === CNT_W'(CNT_MAX)) else begin
            mismatched++;
            $error("[TB] FAIL sat_value: observed %0d expected %0d", stallCount, CNT_MAX);
        end

        // Random traffic over a small register window to provoke dependencies.
        for (int k = 0; k < 600; k++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          $urandom_range(0, 1),
                          ($urandom_range(0, 7) != 0),
                          $urandom_range(0, 7),
                          $urandom_range(0, 7),
                          $urandom_range(0, 1),
                          ($urandom_range(0, 3) != 0),
                          $urandom_range(0, 7),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 7) == 0));
            checkOutput("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
